// File: rtl/bcd_display_driver.sv
// 8-bit capture -> sequential double-dabble -> 4-digit multiplexed 7-seg scan; bcd_o commits 9 edges after load.
// Loads arriving while busy park in a one-deep last-wins slot; BCD_DISPLAY_SIGNED_EN adds two's-complement sign on digit 3.
module bcd_display_driver #(
  parameter int unsigned SCAN_DIV = 1024,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_i,
  input  logic        load,
  output logic [6:0]  seg_o,
  output logic [3:0]  digit_o,
  output logic [11:0] bcd_o,
  output logic        busy
);

  localparam logic [15:0] SCAN_TC = 16'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_COMMIT
  } state_t;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Magnitude fed to the converter; 0x80 negates to itself, which reads as 128.
  function automatic logic [7:0] magnitude(input logic [7:0] raw);
`ifdef BCD_DISPLAY_SIGNED_EN
    return raw[7] ? 8'(8'd0 - raw) : raw;
`else
    return raw;
`endif
  endfunction

  state_t      r_state;
  logic [7:0]  r_shift;
  logic [11:0] r_scratch;
  logic [2:0]  r_iter;
  logic        r_pend_vld;
  logic [7:0]  r_pend_dat;
  logic [11:0] r_bcd;
  logic        r_busy;
  logic [15:0] r_presc;
  logic [1:0]  r_idx;
  logic [3:0]  r_digit;
  logic [6:0]  r_seg;
`ifdef BCD_DISPLAY_SIGNED_EN
  logic        r_sign_conv;
  logic        r_sign;
`endif

  logic [11:0] w_adj;
  logic [7:0]  w_restart_raw;
  logic        w_restart;
  logic        w_tc;
  logic [1:0]  w_idx_nxt;
  logic        w_sign;
  logic        w_blank_h;
  logic        w_blank_t;
  logic [6:0]  w_seg_nxt;

  assign w_adj = {add3(r_scratch[11:8]), add3(r_scratch[7:4]), add3(r_scratch[3:0])};

  // A load coinciding with commit outranks the parked value: last write wins.
  assign w_restart     = load | r_pend_vld;
  assign w_restart_raw = load ? data_i : r_pend_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= 8'd0;
      r_scratch   <= 12'd0;
      r_iter      <= 3'd0;
      r_pend_vld  <= 1'b0;
      r_pend_dat  <= 8'd0;
      r_bcd       <= 12'd0;
      r_busy      <= 1'b0;
`ifdef BCD_DISPLAY_SIGNED_EN
      r_sign_conv <= 1'b0;
      r_sign      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_shift     <= magnitude(data_i);
            r_scratch   <= 12'd0;
            r_iter      <= 3'd0;
            r_busy      <= 1'b1;
            r_state     <= S_CONV;
`ifdef BCD_DISPLAY_SIGNED_EN
            r_sign_conv <= data_i[7];
`endif
          end
        end
        S_CONV: begin
          {r_scratch, r_shift} <= {w_adj[10:0], r_shift, 1'b0};
          r_iter <= r_iter + 3'd1;
          if (r_iter == 3'd7) begin
            r_state <= S_COMMIT;
          end
          if (load) begin
            r_pend_vld <= 1'b1;
            r_pend_dat <= data_i;
          end
        end
        S_COMMIT: begin
          r_bcd <= r_scratch;
`ifdef BCD_DISPLAY_SIGNED_EN
          r_sign <= r_sign_conv;
`endif
          r_pend_vld <= 1'b0;
          if (w_restart) begin
            r_shift     <= magnitude(w_restart_raw);
            r_scratch   <= 12'd0;
            r_iter      <= 3'd0;
            r_state     <= S_CONV;
`ifdef BCD_DISPLAY_SIGNED_EN
            r_sign_conv <= w_restart_raw[7];
`endif
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef BCD_DISPLAY_SIGNED_EN
  assign w_sign = r_sign;
`else
  assign w_sign = 1'b0;
`endif

  assign w_tc      = (r_presc == SCAN_TC);
  assign w_idx_nxt = w_tc ? r_idx + 2'd1 : r_idx;
  assign w_blank_h = BLANK_LZ && (r_bcd[11:8] == 4'd0);
  assign w_blank_t = w_blank_h && (r_bcd[7:4] == 4'd0);

  always_comb begin
    w_seg_nxt = 7'h00;
    case (w_idx_nxt)
      2'd0: w_seg_nxt = seg_of(r_bcd[3:0]);
      2'd1: w_seg_nxt = w_blank_t ? 7'h00 : seg_of(r_bcd[7:4]);
      2'd2: w_seg_nxt = w_blank_h ? 7'h00 : seg_of(r_bcd[11:8]);
      2'd3: w_seg_nxt = w_sign ? 7'h40 : 7'h00;
      default: w_seg_nxt = 7'h00;
    endcase
  end

  // Digit select and segments are registered from the same next index so they never skew.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= 16'd0;
      r_idx   <= 2'd0;
      r_digit <= 4'b0001;
      r_seg   <= 7'h3F;
    end else begin
      r_presc <= w_tc ? 16'd0 : r_presc + 16'd1;
      r_idx   <= w_idx_nxt;
      r_digit <= 4'b0001 << w_idx_nxt;
      r_seg   <= w_seg_nxt;
    end
  end

  assign seg_o   = r_seg;
  assign digit_o = r_digit;
  assign bcd_o   = r_bcd;
  assign busy    = r_busy;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed self-checking bench for bcd_display_driver (SCAN_DIV=4), with a BLANK_LZ=0 twin for blanking checks.
module tb_bcd_display_driver;

  logic        clk;
  logic        rst;
  logic [7:0]  data_i;
  logic        load;
  logic [6:0]  seg_o;
  logic [3:0]  digit_o;
  logic [11:0] bcd_o;
  logic        busy;
  logic [6:0]  seg_nb;
  logic [3:0]  digit_nb;
  logic [11:0] bcd_nb;
  logic        busy_nb;

  int checks = 0;
  int errors = 0;

  bcd_display_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .load(load),
    .seg_o(seg_o), .digit_o(digit_o), .bcd_o(bcd_o), .busy(busy)
  );

  bcd_display_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .data_i(data_i), .load(load),
    .seg_o(seg_nb), .digit_o(digit_nb), .bcd_o(bcd_nb), .busy(busy_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load   = 1'b1;
    data_i = v;
    tick();
    load   = 1'b0;
  endtask

  task automatic convert(input logic [7:0] v);
    do_load(v);
    repeat (9) tick();
  endtask

  // Bounded wait until the scan reaches digit idx; a timeout is a failed comparison.
  task automatic wait_digit(input int idx);
    logic [3:0] oh;
    logic       ok;
    oh = 4'b0001 << idx;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (digit_o === oh) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL scan_wait idx=%0d: digit_o=%b never reached %b", idx, digit_o, oh);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; data_i = 8'd0;
    tick();
    checks++; if (digit_o !== 4'b0001) begin errors++; $display("FAIL reset_digit: got %b want 0001", digit_o); end
    checks++; if (seg_o !== 7'h3F) begin errors++; $display("FAIL reset_seg: got %h want 3F", seg_o); end
    checks++; if (bcd_o !== 12'h000) begin errors++; $display("FAIL reset_bcd: got %h want 000", bcd_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_scan();
    logic [3:0] exp_seq [4];
    exp_seq[0] = 4'b0010; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b1000; exp_seq[3] = 4'b0001;
    repeat (3) tick();
    checks++; if (digit_o !== 4'b0001) begin errors++; $display("FAIL scan_hold: got %b want 0001", digit_o); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (digit_o !== exp_seq[k]) begin errors++; $display("FAIL scan_step%0d: got %b want %b", k, digit_o, exp_seq[k]); end
      if (k < 3) repeat (3) tick();
    end
  endtask

  task automatic test_convert_255();
    do_load(8'd255);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL c255_busy_e0: got %b want 1", busy); end
    repeat (8) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL c255_busy_e8: got %b want 1", busy); end
    checks++; if (bcd_o !== 12'h000) begin errors++; $display("FAIL c255_early: got %h want 000", bcd_o); end
    tick();
    checks++; if (bcd_o !== 12'h255) begin errors++; $display("FAIL c255_bcd: got %h want 255", bcd_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL c255_busy_e9: got %b want 0", busy); end
    wait_digit(0);
    checks++; if (seg_o !== 7'h6D) begin errors++; $display("FAIL c255_ones: got %h want 6D", seg_o); end
    wait_digit(1);
    checks++; if (seg_o !== 7'h6D) begin errors++; $display("FAIL c255_tens: got %h want 6D", seg_o); end
    wait_digit(2);
    checks++; if (seg_o !== 7'h5B) begin errors++; $display("FAIL c255_hund: got %h want 5B", seg_o); end
    wait_digit(3);
    checks++; if (seg_o !== 7'h00) begin errors++; $display("FAIL c255_d3: got %h want 00", seg_o); end
  endtask

  task automatic test_blanking();
    convert(8'd7);
    checks++; if (bcd_o !== 12'h007) begin errors++; $display("FAIL b7_bcd: got %h want 007", bcd_o); end
    wait_digit(0);
    checks++; if (seg_o !== 7'h07) begin errors++; $display("FAIL b7_ones: got %h want 07", seg_o); end
    wait_digit(1);
    checks++; if (seg_o !== 7'h00) begin errors++; $display("FAIL b7_tens_blank: got %h want 00", seg_o); end
    checks++; if (seg_nb !== 7'h3F) begin errors++; $display("FAIL b7_tens_noblank: got %h want 3F", seg_nb); end
    wait_digit(2);
    checks++; if (seg_o !== 7'h00) begin errors++; $display("FAIL b7_hund_blank: got %h want 00", seg_o); end
    checks++; if (seg_nb !== 7'h3F) begin errors++; $display("FAIL b7_hund_noblank: got %h want 3F", seg_nb); end
  endtask

  task automatic test_back_to_back();
    logic bad;
    do_load(8'd42);
    repeat (2) tick();
    do_load(8'd99);
    do_load(8'd100);
    repeat (4) tick();
    tick();
    checks++; if (bcd_o !== 12'h042) begin errors++; $display("FAIL b2b_first: got %h want 042", bcd_o); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", busy); end
    bad = 1'b0;
    repeat (8) begin
      tick();
      if (bcd_o !== 12'h042 || busy !== 1'b1) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL b2b_hold: bcd=%h busy=%b want 042 and 1", bcd_o, busy); end
    tick();
    checks++; if (bcd_o !== 12'h100) begin errors++; $display("FAIL b2b_second: got %h want 100", bcd_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", busy); end
    wait_digit(1);
    checks++; if (seg_o !== 7'h3F) begin errors++; $display("FAIL b2b_tens: got %h want 3F", seg_o); end
    wait_digit(2);
    checks++; if (seg_o !== 7'h06) begin errors++; $display("FAIL b2b_hund: got %h want 06", seg_o); end
  endtask

  task automatic test_load_at_commit();
    do_load(8'd5);
    repeat (8) tick();
    do_load(8'd9);
    checks++; if (bcd_o !== 12'h005) begin errors++; $display("FAIL lac_first: got %h want 005", bcd_o); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lac_busy: got %b want 1", busy); end
    repeat (9) tick();
    checks++; if (bcd_o !== 12'h009) begin errors++; $display("FAIL lac_second: got %h want 009", bcd_o); end
  endtask

  task automatic test_sign();
    logic [11:0] exp_ff;
    logic [6:0]  exp_d3_neg;
    logic [6:0]  exp_ones_ff;
`ifdef BCD_DISPLAY_SIGNED_EN
    exp_ff = 12'h001; exp_d3_neg = 7'h40; exp_ones_ff = 7'h06;
`else
    exp_ff = 12'h255; exp_d3_neg = 7'h00; exp_ones_ff = 7'h6D;
`endif
    convert(8'h80);
    checks++; if (bcd_o !== 12'h128) begin errors++; $display("FAIL s80_bcd: got %h want 128", bcd_o); end
    wait_digit(3);
    checks++; if (seg_o !== exp_d3_neg) begin errors++; $display("FAIL s80_d3: got %h want %h", seg_o, exp_d3_neg); end
    convert(8'hFF);
    checks++; if (bcd_o !== exp_ff) begin errors++; $display("FAIL sff_bcd: got %h want %h", bcd_o, exp_ff); end
    wait_digit(0);
    checks++; if (seg_o !== exp_ones_ff) begin errors++; $display("FAIL sff_ones: got %h want %h", seg_o, exp_ones_ff); end
    wait_digit(3);
    checks++; if (seg_o !== exp_d3_neg) begin errors++; $display("FAIL sff_d3: got %h want %h", seg_o, exp_d3_neg); end
    convert(8'h7F);
    checks++; if (bcd_o !== 12'h127) begin errors++; $display("FAIL s7f_bcd: got %h want 127", bcd_o); end
    wait_digit(3);
    checks++; if (seg_o !== 7'h00) begin errors++; $display("FAIL s7f_d3: got %h want 00", seg_o); end
  endtask

  task automatic test_reset_mid_conv();
    do_load(8'd200);
    tick();
    do_load(8'd55);
    tick();
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
    checks++; if (bcd_o !== 12'h000) begin errors++; $display("FAIL rmid_bcd: got %h want 000", bcd_o); end
    checks++; if (digit_o !== 4'b0001) begin errors++; $display("FAIL rmid_digit: got %b want 0001", digit_o); end
    checks++; if (seg_o !== 7'h3F) begin errors++; $display("FAIL rmid_seg: got %h want 3F", seg_o); end
    tick();
    rst = 1'b0;
    repeat (14) tick();
    checks++; if (bcd_o !== 12'h000) begin errors++; $display("FAIL rmid_nocommit: got %h want 000", bcd_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_idle: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_convert_255();
    test_blanking();
    test_back_to_back();
    test_load_at_commit();
    test_sign();
    test_reset_mid_conv();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
